// File: rtl/interconn_pkg.sv
// rtl/interconn_pkg.sv - shared defaults and types for the interconnect send scheduler
// Purpose: default MVU count, word width and address width, plus the
//          destination-index type sized from the default MVU count.
package interconn_pkg;

  localparam int N_DEF     = 8;
  localparam int W_DEF     = 64;
  localparam int BADDR_DEF = 15;
  localparam int DW_DEF    = $clog2(N_DEF);

  typedef logic [DW_DEF-1:0] dst_idx_t;

endpackage

// File: rtl/interconn_rr_sched_rr_arbiter.sv
// rtl/interconn_rr_sched_rr_arbiter.sv - rotate-priority find-first arbiter for one destination
// Purpose: picks the first asserted request at or after ptr, scanning upward mod N.
// Ports:
//   req     in  N   request vector
//   ptr     in  DW  highest-priority index
//   en      in  1   arbitration enable; when low, nothing is granted
//   gnt     out N   one-hot grant
//   gnt_idx out DW  index of the granted request (0 when none)
//   any     out 1   a grant was issued
module rr_arbiter #(
  parameter int N = 8,
  localparam int DW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [DW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [DW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    logic [DW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      // N is a power of two, so DW-bit addition wraps modulo N for free.
      idx = ptr + DW'(k);
      if (en && !any && req[idx]) begin
        any      = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interconn_rr_sched.sv
// rtl/interconn_rr_sched.sv - round-robin send scheduler in front of the interconnect
// Purpose: accepts word transfers from N sources, grants at most one source per
//          destination per cycle with rotating priority, and drives registered
//          send_* outputs one cycle after acceptance.
// Ports:
//   clk, clr               clock, synchronous active-high reset
//   req_valid/req_ready    per-source handshake (ready is combinational)
//   req_dst/addr/word      per-source destination, address and data
//   dst_busy               per-destination stall
//   send_to/en/addr/word   registered per-source outputs to the interconnect
//   grant_cnt              running count of accepted transfers (wraps)
module interconn_rr_sched
  import interconn_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int BADDR = BADDR_DEF,
  localparam int DW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N-1:0]     req_valid,
  input  logic [DW-1:0]    req_dst   [N],
  input  logic [BADDR-1:0] req_addr  [N],
  input  logic [W-1:0]     req_word  [N],
  output logic [N-1:0]     req_ready,
  input  logic [N-1:0]     dst_busy,
  output logic [N-1:0]     send_to   [N],
  output logic [N-1:0]     send_en,
  output logic [BADDR-1:0] send_addr [N],
  output logic [W-1:0]     send_word [N],
  output logic [31:0]      grant_cnt
);

  logic [N-1:0]  cand    [N];
  logic [N-1:0]  gnt     [N];
  logic [DW-1:0] gnt_idx [N];
  logic [DW-1:0] ptr     [N];
  logic [N-1:0]  arb_en;
  logic [N-1:0]  arb_any;

  // cand[d][i]: source i has a valid request aimed at destination d.
  always_comb begin
    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < N; i++) begin
        cand[d][i] = req_valid[i] && (req_dst[i] == DW'(d));
      end
    end
  end

  // A busy destination or reset suppresses the grant entirely, so its
  // pointer cannot move and arbitration resumes from the same place.
  assign arb_en = ~dst_busy & {N{~clr}};

  for (genvar d = 0; d < N; d++) begin : g_arb
    rr_arbiter #(.N(N)) u_arb (
      .req     (cand[d]),
      .ptr     (ptr[d]),
      .en      (arb_en[d]),
      .gnt     (gnt[d]),
      .gnt_idx (gnt_idx[d]),
      .any     (arb_any[d])
    );
  end

  // Each source targets one destination, so its ready is just its bit in
  // that destination's grant vector.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_ready[i] = gnt[req_dst[i]][i];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int d = 0; d < N; d++) begin
        ptr[d] <= '0;
      end
    end else begin
      for (int d = 0; d < N; d++) begin
        if (arb_any[d]) begin
          ptr[d] <= gnt_idx[d] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      send_en   <= '0;
      grant_cnt <= '0;
      for (int i = 0; i < N; i++) begin
        send_to[i]   <= '0;
        send_addr[i] <= '0;
        send_word[i] <= '0;
      end
    end else begin
      send_en   <= req_ready;
      grant_cnt <= grant_cnt + 32'($countones(req_ready));
      for (int i = 0; i < N; i++) begin
        send_to[i] <= req_ready[i] ? ({{(N-1){1'b0}}, 1'b1} << req_dst[i]) : '0;
        if (req_ready[i]) begin
          send_addr[i] <= req_addr[i];
          send_word[i] <= req_word[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_interconn_rr_sched.sv
// tb/tb_interconn_rr_sched.sv - directed self-checking bench for interconn_rr_sched
module tb_interconn_rr_sched;

  localparam int N     = 8;
  localparam int W     = 64;
  localparam int BADDR = 15;
  localparam int DW    = 3;

  logic             clk;
  logic             clr;
  logic [N-1:0]     req_valid;
  logic [DW-1:0]    req_dst   [N];
  logic [BADDR-1:0] req_addr  [N];
  logic [W-1:0]     req_word  [N];
  logic [N-1:0]     req_ready;
  logic [N-1:0]     dst_busy;
  logic [N-1:0]     send_to   [N];
  logic [N-1:0]     send_en;
  logic [BADDR-1:0] send_addr [N];
  logic [W-1:0]     send_word [N];
  logic [31:0]      grant_cnt;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_cnt;

  interconn_rr_sched #(.N(N), .W(W), .BADDR(BADDR)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_dst   (req_dst),
    .req_addr  (req_addr),
    .req_word  (req_word),
    .req_ready (req_ready),
    .dst_busy  (dst_busy),
    .send_to   (send_to),
    .send_en   (send_en),
    .send_addr (send_addr),
    .send_word (send_word),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    dst_busy = '0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_dst[i] = '0; req_addr[i] = '0; req_word[i] = '0;
    end
    step();
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 8'h00) begin
      failures++; $display("FAIL reset_ready got=%h exp=00", req_ready);
    end
    step();
    checks++;
    if (send_en !== 8'h00) begin
      failures++; $display("FAIL reset_send_en got=%h exp=00", send_en);
    end
    checks++;
    if (grant_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_grant_cnt got=%0d exp=0", grant_cnt);
    end
    checks++;
    if (send_to[0] !== 8'h00 || send_addr[0] !== '0 || send_word[7] !== '0) begin
      failures++;
      $display("FAIL reset_regs to0=%h addr0=%h word7=%h exp=0", send_to[0], send_addr[0], send_word[7]);
    end
    clr = 1'b0;
    req_valid = '0;
    exp_cnt = 0;
  endtask

  task automatic test_single();
    req_dst[3]  = 3'd5;
    req_addr[3] = 15'd7;
    req_word[3] = 64'hdeadbeefdeadbeef;
    req_valid   = 8'h08;
    #1;
    checks++;
    if (req_ready !== 8'h08) begin
      failures++; $display("FAIL single_ready got=%h exp=08", req_ready);
    end
    step();
    req_valid = '0;
    exp_cnt = exp_cnt + 1;
    checks++;
    if (send_en !== 8'h08) begin
      failures++; $display("FAIL single_send_en got=%h exp=08", send_en);
    end
    checks++;
    if (send_to[3] !== 8'b0010_0000) begin
      failures++; $display("FAIL single_send_to got=%b exp=00100000", send_to[3]);
    end
    checks++;
    if (send_addr[3] !== 15'd7 || send_word[3] !== 64'hdeadbeefdeadbeef) begin
      failures++; $display("FAIL single_data addr=%h word=%h exp=7/deadbeefdeadbeef", send_addr[3], send_word[3]);
    end
    checks++;
    if (grant_cnt !== exp_cnt) begin
      failures++; $display("FAIL single_cnt got=%0d exp=%0d", grant_cnt, exp_cnt);
    end
    step();
    checks++;
    if (send_en !== 8'h00 || send_to[3] !== 8'h00 || send_addr[3] !== 15'd7) begin
      failures++; $display("FAIL single_idle en=%h to=%h addr=%h exp=00/00/7", send_en, send_to[3], send_addr[3]);
    end
  endtask

  task automatic test_contention();
    int order [6];
    order = '{0, 2, 6, 0, 2, 6};
    req_dst[0] = 3'd1; req_dst[2] = 3'd1; req_dst[6] = 3'd1;
    req_addr[0] = 15'h100; req_addr[2] = 15'h102; req_addr[6] = 15'h106;
    req_valid = 8'b0100_0101;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (req_ready !== (8'h01 << order[k])) begin
        failures++; $display("FAIL contention_ready k=%0d got=%h exp_src=%0d", k, req_ready, order[k]);
      end
      step();
      exp_cnt = exp_cnt + 1;
      checks++;
      if (send_en !== (8'h01 << order[k]) || send_to[order[k]] !== 8'h02) begin
        failures++; $display("FAIL contention_send k=%0d en=%h to=%h exp_src=%0d", k, send_en, send_to[order[k]], order[k]);
      end
    end
    req_valid = '0;
    checks++;
    if (grant_cnt !== exp_cnt) begin
      failures++; $display("FAIL contention_cnt got=%0d exp=%0d", grant_cnt, exp_cnt);
    end
    checks++;
    if (send_addr[6] !== 15'h106) begin
      failures++; $display("FAIL contention_addr got=%h exp=106", send_addr[6]);
    end
  endtask

  task automatic test_parallel();
    for (int i = 0; i < N; i++) begin
      req_dst[i]  = DW'((i + 1) % N);
      req_addr[i] = BADDR'(i + 16);
      req_word[i] = 64'h1111_0000_0000_0000 + 64'(i);
    end
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 8'hFF) begin
      failures++; $display("FAIL parallel_ready got=%h exp=ff", req_ready);
    end
    step();
    req_valid = '0;
    exp_cnt = exp_cnt + 8;
    checks++;
    if (send_en !== 8'hFF) begin
      failures++; $display("FAIL parallel_send_en got=%h exp=ff", send_en);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (send_to[i] !== (8'h01 << ((i + 1) % N)) || send_word[i] !== 64'h1111_0000_0000_0000 + 64'(i)) begin
        failures++; $display("FAIL parallel_send src=%0d to=%h word=%h", i, send_to[i], send_word[i]);
      end
    end
    checks++;
    if (grant_cnt !== exp_cnt) begin
      failures++; $display("FAIL parallel_cnt got=%0d exp=%0d", grant_cnt, exp_cnt);
    end
  endtask

  task automatic test_busy_stall();
    req_dst[4] = 3'd0; req_dst[5] = 3'd0;
    req_valid = 8'h30;
    dst_busy  = 8'h01;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 8'h00) begin
        failures++; $display("FAIL busy_ready k=%0d got=%h exp=00", k, req_ready);
      end
      step();
    end
    checks++;
    if (send_en !== 8'h00) begin
      failures++; $display("FAIL busy_send_en got=%h exp=00", send_en);
    end
    dst_busy = '0;
    #1;
    checks++;
    if (req_ready !== 8'h10) begin
      failures++; $display("FAIL busy_resume4 got=%h exp=10", req_ready);
    end
    step();
    exp_cnt = exp_cnt + 1;
    checks++;
    if (req_ready !== 8'h20) begin
      failures++; $display("FAIL busy_resume5 got=%h exp=20", req_ready);
    end
    step();
    exp_cnt = exp_cnt + 1;
    req_valid = '0;
    checks++;
    if (send_en !== 8'h20 || send_to[5] !== 8'h01) begin
      failures++; $display("FAIL busy_send5 en=%h to=%h exp=20/01", send_en, send_to[5]);
    end
  endtask

  task automatic test_wrap();
    int order [3];
    order = '{7, 1, 7};
    req_dst[6] = 3'd2;
    req_valid = 8'h40;
    #1;
    checks++;
    if (req_ready !== 8'h40) begin
      failures++; $display("FAIL wrap_prime got=%h exp=40", req_ready);
    end
    step();
    exp_cnt = exp_cnt + 1;
    req_dst[7] = 3'd2; req_dst[1] = 3'd2;
    req_valid = 8'h82;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== (8'h01 << order[k])) begin
        failures++; $display("FAIL wrap_ready k=%0d got=%h exp_src=%0d", k, req_ready, order[k]);
      end
      step();
      exp_cnt = exp_cnt + 1;
    end
    req_valid = '0;
    checks++;
    if (grant_cnt !== exp_cnt) begin
      failures++; $display("FAIL wrap_cnt got=%0d exp=%0d", grant_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    // Pointer for dst 3 sits at 3 after the parallel test (source 2 won it).
    for (int i = 0; i < N; i++) req_dst[i] = 3'd3;
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 8'h08) begin
      failures++; $display("FAIL mid_ready0 got=%h exp=08", req_ready);
    end
    step();
    checks++;
    if (req_ready !== 8'h10) begin
      failures++; $display("FAIL mid_ready1 got=%h exp=10", req_ready);
    end
    step();
    clr = 1'b1;
    #1;
    checks++;
    if (req_ready !== 8'h00 || send_en !== 8'h10) begin
      failures++; $display("FAIL mid_clr_cycle ready=%h en=%h exp=00/10", req_ready, send_en);
    end
    step();
    clr = 1'b0;
    #1;
    checks++;
    if (send_en !== 8'h00 || grant_cnt !== 32'd0) begin
      failures++; $display("FAIL mid_after_clr en=%h cnt=%0d exp=00/0", send_en, grant_cnt);
    end
    checks++;
    if (req_ready !== 8'h01) begin
      failures++; $display("FAIL mid_resume_prio got=%h exp=01", req_ready);
    end
    step();
    checks++;
    if (req_ready !== 8'h02 || send_en !== 8'h01 || grant_cnt !== 32'd1) begin
      failures++; $display("FAIL mid_resume_next ready=%h en=%h cnt=%0d exp=02/01/1", req_ready, send_en, grant_cnt);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_parallel();
    test_busy_stall();
    test_wrap();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interconn_rr_sched.md
# interconn_rr_sched

Round-robin send scheduler placed in front of `interconn_priority`. It collects word-transfer requests from N MVUs over a valid/ready handshake and grants at most one source per destination per cycle. Grants rotate fairly among sources. It then drives the interconnect's `send_*` inputs from registers, so MVUs never collide at a destination and no source starves.

## Interface
Parameters:
- `N`, 8, number of MVUs (sources and destinations); power of two, ≥ 2
- `W`, 64, data word width
- `BADDR`, 15, destination memory address width
- `DW`, `$clog2(N)`, destination index width (derived; not overridden)

Ports:
- `clk`  in  1  the single clock
- `clr`  in  1  reset; synchronous, active-high
- `req_valid[N]`  in  1 each  source i has a transfer pending
- `req_dst[N]`  in  DW each  destination MVU index of source i
- `req_addr[N]`  in  BADDR each  destination memory address
- `req_word[N]`  in  W each  data word
- `req_ready[N]`  out  1 each  source i's request is accepted this cycle
- `dst_busy`  in  N  bit d high: destination d accepts nothing this cycle
- `send_to[N]`  out  N each  one-hot destination select, to interconnect
- `send_en[N]`  out  1 each  send strobe, to interconnect
- `send_addr[N]`  out  BADDR each  registered address
- `send_word[N]`  out  W each  registered word
- `grant_cnt`  out  32  total accepted transfers since reset; wraps at 2^32

## Operation
- Each destination d has a round-robin pointer `ptr[d]` (DW bits), which is the highest-priority source.
- Candidates for d are all i with `req_valid[i]` and `req_dst[i]==d`.
- Winner for d is the first candidate at or after `ptr[d]`, scanning upward modulo N; scan order is ptr, ptr+1, …, N-1, 0, …, ptr-1.
- Handshake: `req_ready[i]` = 1 iff i wins its destination, `dst_busy[req_dst[i]]`=0, and `clr`=0.
- A transfer occurs when `req_valid[i]` and `req_ready[i]` are both 1.
- Each source has one destination, so a source wins at most once per cycle. Up to N transfers per cycle are possible when the destinations are distinct.
- On a transfer from i to d, `ptr[d]` <= (i+1) mod N, wrapping N-1 to 0.
- Pointers of destinations with no transfer stay unchanged, including while busy.
- Sources must hold `req_dst`, `req_addr` and `req_word` stable while valid and not ready. Deasserting valid before ready is allowed, and the request is dropped.
- Fairness: a valid source waits at most N-1 grants to its destination (busy cycles excluded).
- `grant_cnt` adds the popcount of transfers each cycle.

## Timing
- `req_ready` is combinational from `req_valid`, `req_dst`, `dst_busy`, `ptr` and `clr`. It has no path from any `send_*` output.
- Latency is 1 cycle. A transfer in cycle t gives, in cycle t+1:
  - `send_en[i]`=1
  - `send_to[i]`=1<<d
  - `send_addr[i]`/`send_word[i]` = the accepted values
- The cycle after a non-transfer has `send_en[i]`=0 and `send_to[i]`=0. `send_addr` and `send_word` hold their last values.
- Back-to-back transfers from one source can occur on consecutive cycles, giving `send_en` high continuously.
- Reset values: all `send_en`=0, `send_to`=0, `send_addr`=0, `send_word`=0, `req_ready`=0, `ptr[*]`=0, `grant_cnt`=0.
- `clr` high mid-operation:
  - no transfer occurs in that cycle
  - all registers take their reset values at the next edge
  - a `send_en` pulse issued the previous cycle is cut off
- `dst_busy[d]` rising while candidates wait: no grant for d and no pointer change. Arbitration resumes from the same pointer.
- Simultaneous events: a transfer that coincides with `grant_cnt` wrap counts modulo 2^32.

## Structure
- Shared package `interconn_pkg`: the `N`, `W`, `BADDR` defaults and a `dst_idx_t` typedef (DW bits).
- One sub-module, `rr_arbiter`:
  - parameter `N`
  - inputs: `req[N]`, `ptr`, `en`
  - outputs: one-hot `gnt[N]`, `gnt_idx`, `any`
  - combinational rotate-priority find-first
  - instantiated N times, one per destination
- The top holds the pointers, output registers and counter.

## Test plan
- Single request: after reset, source 3 → dst 5, addr 7, word 'hdeadbeefdeadbeef.
  - `req_ready[3]`=1 in the same cycle.
  - Next cycle: `send_en[3]`=1, `send_to[3]`=8'b0010_0000, addr/word match.
  - `grant_cnt`=1.
- Contention rotation: sources 0, 2, 6 hold valid to dst 1 for 6 cycles.
  - Grant order: 0, 2, 6, 0, 2, 6.
  - `ptr[1]` sequence: 1, 3, 7, 1, 3, 7.
- Parallel distinct: source i → dst (i+1) mod 8 for all i.
  - All 8 ready in one cycle.
  - Next cycle, all `send_en` are 1 with the correct one-hot `send_to`.
  - `grant_cnt` +8.
- Busy stall: sources 4 and 5 → dst 0 with `dst_busy[0]`=1 for 3 cycles, then 0.
  - No ready and `ptr[0]`=0 during the busy cycles.
  - Then source 4 is granted, followed by source 5.
- Wrap-around: `ptr[2]`=7 (after a grant to 6), with sources 7 and 1 → dst 2.
  - Grant 7 first; `ptr[2]`=0.
  - Then grant 1; `ptr[2]`=2.
- Reset mid-stream: continuous traffic, `clr` held for 1 cycle.
  - No ready that cycle.
  - Next cycle: all `send_en` are 0, `ptr`=0 and `grant_cnt`=0.
  - Traffic resumes with source-0 priority.
